// File: rtl/ex_pkg.sv
// Shared opcode map, CPU state codes and widths for the 16-bit pipeline.
package ex_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 8;

    localparam logic IDLE = 1'b0;
    localparam logic EXEC = 1'b1;

    localparam logic [4:0] NOP   = 5'b00000;
    localparam logic [4:0] HALT  = 5'b00001;
    localparam logic [4:0] LOAD  = 5'b00010;
    localparam logic [4:0] STORE = 5'b00011;
    localparam logic [4:0] SLL   = 5'b00100;
    localparam logic [4:0] SLA   = 5'b00101;
    localparam logic [4:0] SRL   = 5'b00110;
    localparam logic [4:0] SRA   = 5'b00111;
    localparam logic [4:0] ADD   = 5'b01000;
    localparam logic [4:0] ADDI  = 5'b01001;
    localparam logic [4:0] SUB   = 5'b01010;
    localparam logic [4:0] SUBI  = 5'b01011;
    localparam logic [4:0] CMP   = 5'b01100;
    localparam logic [4:0] AND   = 5'b01101;
    localparam logic [4:0] OR    = 5'b01110;
    localparam logic [4:0] XOR   = 5'b01111;
    localparam logic [4:0] LDIH  = 5'b10000;
    localparam logic [4:0] ADDC  = 5'b10001;
    localparam logic [4:0] SUBC  = 5'b10010;
    localparam logic [4:0] JUMP  = 5'b11000;
    localparam logic [4:0] JMPR  = 5'b11001;
    localparam logic [4:0] BZ    = 5'b11010;
    localparam logic [4:0] BNZ   = 5'b11011;
    localparam logic [4:0] BN    = 5'b11100;
    localparam logic [4:0] BNN   = 5'b11101;
    localparam logic [4:0] BC    = 5'b11110;
    localparam logic [4:0] BNC   = 5'b11111;

endpackage

// File: rtl/ex_if.sv
// Decode-to-EX operand bus and EX/MEM result bus.
interface ex_if;
    import ex_pkg::*;

    logic              state;
    logic [DATA_W-1:0] ex_ir;
    logic [DATA_W-1:0] reg_A;
    logic [DATA_W-1:0] reg_B;
    logic [DATA_W-1:0] smdr;
    logic [DATA_W-1:0] mem_ir;
    logic [DATA_W-1:0] reg_C;
    logic [DATA_W-1:0] smdr1;
    logic              dw;
    logic              zf;
    logic              nf;
    logic              cf;
    logic              br_en;
    logic [ADDR_W-1:0] br_addr;

    modport master (
        output state, ex_ir, reg_A, reg_B, smdr,
        input  mem_ir, reg_C, smdr1, dw,
        input  zf, nf, cf, br_en, br_addr
    );

    modport slave (
        input  state, ex_ir, reg_A, reg_B, smdr,
        output mem_ir, reg_C, smdr1, dw,
        output zf, nf, cf, br_en, br_addr
    );

endinterface

// File: rtl/ex_alu.sv
// Combinational ALU: arithmetic, logic, shifts and address sums,
// plus which flags the opcode is allowed to update.
module ex_alu
    import ex_pkg::*;
(
    input  logic [4:0]        op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic              cin_i,
    output logic [DATA_W-1:0] result_o,
    output logic              cout_o,
    output logic              upd_zn_o,
    output logic              upd_c_o
);

    logic            c_in;
    logic [DATA_W:0] add_w;
    logic [DATA_W:0] sub_w;
    logic [DATA_W-1:0] sla_w;
    logic [3:0]      sh;
    logic            is_add;
    logic            is_sub;
    logic            is_addr;
    logic            is_logic;
    logic            is_shift;

    assign sh       = b_i[3:0];
    assign c_in     = cin_i & ((op_i == ADDC) | (op_i == SUBC));
    assign add_w    = {1'b0, a_i} + {1'b0, b_i} + {{DATA_W{1'b0}}, c_in};
    // Bit 16 of the widened difference is the unsigned borrow.
    assign sub_w    = {1'b0, a_i} - {1'b0, b_i} - {{DATA_W{1'b0}}, c_in};
    assign sla_w    = a_i << sh;

    assign is_add   = op_i inside {ADD, ADDI, LDIH, ADDC};
    assign is_sub   = op_i inside {SUB, SUBI, CMP, SUBC};
    assign is_addr  = op_i inside {LOAD, STORE, JMPR,
                                   BZ, BNZ, BN, BNN, BC, BNC};
    assign is_logic = op_i inside {AND, OR, XOR};
    assign is_shift = op_i inside {SLL, SRL, SLA, SRA};

    always_comb begin
        result_o = '0;
        cout_o   = 1'b0;
        upd_zn_o = 1'b0;
        upd_c_o  = 1'b0;
        unique case (1'b1)
            is_add: begin
                result_o = add_w[DATA_W-1:0];
                cout_o   = add_w[DATA_W];
                upd_zn_o = 1'b1;
                upd_c_o  = 1'b1;
            end
            is_sub: begin
                result_o = sub_w[DATA_W-1:0];
                cout_o   = sub_w[DATA_W];
                upd_zn_o = 1'b1;
                upd_c_o  = 1'b1;
            end
            is_addr: begin
                result_o = add_w[DATA_W-1:0];
            end
            is_logic: begin
                upd_zn_o = 1'b1;
                unique case (op_i)
                    AND:     result_o = a_i & b_i;
                    OR:      result_o = a_i | b_i;
                    default: result_o = a_i ^ b_i;
                endcase
            end
            is_shift: begin
                upd_zn_o = 1'b1;
                unique case (op_i)
                    SLL:     result_o = a_i << sh;
                    SRL:     result_o = a_i >> sh;
                    SLA:     result_o = {a_i[DATA_W-1], sla_w[DATA_W-2:0]};
                    default: result_o = $signed(a_i) >>> sh;
                endcase
            end
            default: begin
                result_o = '0;
            end
        endcase
    end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ALU, flag register, branch resolution with a
// one-slot squash, and the EX/MEM pipeline registers.
module ex_stage
    import ex_pkg::*;
(
    input  logic clock,
    input  logic reset,
    ex_if.slave  bus
);

    logic [4:0]        op;
    logic              adv;
    logic              taken;
    logic [DATA_W-1:0] alu_res;
    logic              alu_cout;
    logic              upd_zn;
    logic              upd_c;

    logic [DATA_W-1:0] mem_ir_q, mem_ir_d;
    logic [DATA_W-1:0] reg_c_q, reg_c_d;
    logic [DATA_W-1:0] smdr1_q, smdr1_d;
    logic              dw_q, dw_d;
    logic              zf_q, zf_d;
    logic              nf_q, nf_d;
    logic              cf_q, cf_d;
    logic              br_en_q, br_en_d;
    logic [ADDR_W-1:0] br_addr_q, br_addr_d;
    logic              squash_q, squash_d;

    assign op  = bus.ex_ir[15:11];
    assign adv = (bus.state == EXEC);

    ex_alu u_alu (
        .op_i    (op),
        .a_i     (bus.reg_A),
        .b_i     (bus.reg_B),
        .cin_i   (cf_q),
        .result_o(alu_res),
        .cout_o  (alu_cout),
        .upd_zn_o(upd_zn),
        .upd_c_o (upd_c)
    );

    always_comb begin
        taken = 1'b0;
        case (op)
            BZ:      taken = zf_q;
            BNZ:     taken = !zf_q;
            BN:      taken = nf_q;
            BNN:     taken = !nf_q;
            BC:      taken = cf_q;
            BNC:     taken = !cf_q;
            JMPR:    taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        mem_ir_d  = mem_ir_q;
        reg_c_d   = reg_c_q;
        smdr1_d   = smdr1_q;
        dw_d      = dw_q;
        zf_d      = zf_q;
        nf_d      = nf_q;
        cf_d      = cf_q;
        br_en_d   = br_en_q;
        br_addr_d = br_addr_q;
        squash_d  = squash_q;
        if (adv) begin
            if (squash_q) begin
                // Wrong-path slot behind a taken branch becomes a bubble.
                mem_ir_d  = '0;
                reg_c_d   = '0;
                smdr1_d   = '0;
                dw_d      = 1'b0;
                br_en_d   = 1'b0;
                br_addr_d = '0;
                squash_d  = 1'b0;
            end else begin
                mem_ir_d  = bus.ex_ir;
                reg_c_d   = alu_res;
                smdr1_d   = bus.smdr;
                dw_d      = (op == STORE);
                br_en_d   = taken;
                br_addr_d = taken ? alu_res[ADDR_W-1:0] : '0;
                squash_d  = taken;
                if (upd_zn) begin
                    zf_d = (alu_res == '0);
                    nf_d = alu_res[DATA_W-1];
                end
                if (upd_c) begin
                    cf_d = alu_cout;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_ir_q  <= '0;
            reg_c_q   <= '0;
            smdr1_q   <= '0;
            dw_q      <= 1'b0;
            zf_q      <= 1'b0;
            nf_q      <= 1'b0;
            cf_q      <= 1'b0;
            br_en_q   <= 1'b0;
            br_addr_q <= '0;
            squash_q  <= 1'b0;
        end else begin
            mem_ir_q  <= mem_ir_d;
            reg_c_q   <= reg_c_d;
            smdr1_q   <= smdr1_d;
            dw_q      <= dw_d;
            zf_q      <= zf_d;
            nf_q      <= nf_d;
            cf_q      <= cf_d;
            br_en_q   <= br_en_d;
            br_addr_q <= br_addr_d;
            squash_q  <= squash_d;
        end
    end

    assign bus.mem_ir  = mem_ir_q;
    assign bus.reg_C   = reg_c_q;
    assign bus.smdr1   = smdr1_q;
    assign bus.dw      = dw_q;
    assign bus.zf      = zf_q;
    assign bus.nf      = nf_q;
    assign bus.cf      = cf_q;
    assign bus.br_en   = br_en_q;
    assign bus.br_addr = br_addr_q;

endmodule
